shift_deser: RTL and testbench
==============================

Name: shift_deser

Overview:
- Serial-in, parallel-out receiver: the receive end of the team's 4-bit parallel-load shift/rotate register used as a serialiser.
- Collects WIDTH serial bits, MSB-first or LSB-first, into a word.
- Presents the word through a one-deep output holding register with a valid/ready handshake.
- Shifting continues while a word is held; a sticky overrun flag reports lost words.

Parameters:
- WIDTH, 4, word width in bits (≥2).
- CNT_W, $clog2(WIDTH)+1, bit-counter width.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on this edge.
- msb_first  input  1  1: first bit received lands in dout[WIDTH-1]; 0: first bit lands in dout[0].
- sync_clr  input  1  synchronous abort of the partial word.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout.
- ovr  output  1  sticky overrun flag.
- ovr_clr  input  1  clears ovr.
- bit_cnt  output  CNT_W  bits collected in the current partial word, 0..WIDTH-1.

Behaviour:
- Reset (rst=0, async):
  - dout=0, dout_valid=0, ovr=0, bit_cnt=0.
  - Shift register=0, latched direction=1, both FSMs in their idle state.
- Shift FSM, states IDLE (bit_cnt=0) and BUSY:
  - IDLE, on sin_valid: latch msb_first, capture the bit, bit_cnt=1, go to BUSY.
  - msb_first is sampled only on the first bit of a word; changes mid-word are ignored.
- Shift rules:
  - Latched msb_first=1: sh <= {sh[WIDTH-2:0], sin}, i.e. shift left with the new bit into the LSB.
  - Latched msb_first=0: sh <= {sin, sh[WIDTH-1:1]}, i.e. shift right with the new bit into the MSB.
- BUSY:
  - On each sin_valid, bit_cnt increments.
  - On the WIDTH-th bit, the completed word (including that bit) goes to the output stage on the same edge.
  - bit_cnt then returns to 0 and the FSM to IDLE.
  - Back-to-back words need no idle gap.
- Latency: dout/dout_valid update on the clock edge that samples the last bit, so they are visible the following cycle.
- sin_valid=0: hold all shift state; no timeout.
- sync_clr=1: discard the partial word, bit_cnt=0, go to IDLE. It takes priority over a simultaneous sin_valid, whose bit is dropped. The output stage and ovr are unaffected.
- Output FSM, states EMPTY (dout_valid=0) and FULL (dout_valid=1):
  - Handshake occurs when dout_valid && dout_ready on an edge; the word is consumed.
  - dout is stable while FULL and not consumed.
  - dout_ready is ignored while EMPTY.
- Word completes while EMPTY: load dout, go to FULL.
- Word completes while FULL and consumed on the same edge: load the new word, stay FULL. No bubble, no overrun.
- Word completes while FULL and not consumed:
  - The new word is discarded and dout is unchanged.
  - ovr <= 1.
- ovr is sticky until ovr_clr=1. If a new overrun and ovr_clr occur on the same edge, the set wins.
- Reset mid-word or mid-hold: everything returns to reset values immediately. A partial word is lost and ovr is not set.

Decomposition:
- Shared package:
  - DESER_WIDTH_DEF=4.
  - Shift-FSM enum {SH_IDLE, SH_BUSY}.
  - Output-FSM enum {OUT_EMPTY, OUT_FULL}.
  - Direction encoding constants DIR_MSB_FIRST=1, DIR_LSB_FIRST=0.
- Sub-module deser_shift_core: shift register, bit counter, direction latch, sync_clr.
  - Outputs word_done (1-cycle pulse) and word.
- The top holds the output FSM, handshake and ovr.

Test Plan (WIDTH=4):
1. MSB-first: msb_first=1, sin=1,0,1,1 on 4 consecutive cycles, dout_ready=0 -> dout=4'b1011 and dout_valid=1 the cycle after bit 4; bit_cnt reads 1,2,3,0.
2. LSB-first: msb_first=0, sin=1,0,1,1 -> dout=4'b1101; toggling msb_first after bit 1 leaves the result unchanged.
3. Overrun: receive 4'hA with dout_ready=0, then receive 4'h5 -> dout stays 4'hA and ovr=1. Then pulse ovr_clr -> ovr=0, unless a third word completes on the same edge, in which case ovr stays 1.
4. Streaming: dout_ready=1 with continuous sin_valid for words 4'h3, 4'hC, 4'h9 -> each word is presented exactly once, ovr=0, and there is no idle gap between bits.
5. Abort: after 2 bits, sync_clr=1 together with sin_valid=1 -> bit_cnt=0 and that bit is dropped; the next 4 bits form a clean word.
6. Async reset: assert rst=0 mid-clock-cycle with dout_valid=1, ovr=1 and bit_cnt=2 -> all outputs are 0 immediately, without waiting for a clock edge; normal reception resumes after rst=1.

Source files
------------

// File: rtl/shift_deser_pkg.sv
// rtl/shift_deser_pkg.sv - shared types and constants for the serial-in parallel-out receiver
package shift_deser_pkg;

    localparam int DESER_WIDTH_DEF = 4;

    typedef enum logic {SH_IDLE, SH_BUSY} sh_state_e;
    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

    localparam logic DIR_MSB_FIRST = 1'b1;
    localparam logic DIR_LSB_FIRST = 1'b0;

endpackage

// File: rtl/deser_shift_core.sv
// rtl/deser_shift_core.sv - shift register, bit counter and direction latch of the receiver
module deser_shift_core
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             msb_first,
    input  logic             sync_clr,
    output logic             word_done,
    output logic [WIDTH-1:0] word,
    output logic [CNT_W-1:0] bit_cnt
);

    sh_state_e        state_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             dir_d;

    // Direction is taken live on the first bit of a word, then held for the rest of it.
    always_comb begin
        dir_d     = (state_q == SH_IDLE) ? msb_first : dir_q;
        sh_d      = (dir_d == DIR_MSB_FIRST) ? {sh_q[WIDTH-2:0], sin}
                                             : {sin, sh_q[WIDTH-1:1]};
        word_done = sin_valid && !sync_clr && (state_q == SH_BUSY) &&
                    (cnt_q == CNT_W'(WIDTH - 1));
    end

    assign word    = sh_d;
    assign bit_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SH_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_MSB_FIRST;
        end else if (sync_clr) begin
            state_q <= SH_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else if (sin_valid) begin
            sh_q  <= sh_d;
            dir_q <= dir_d;
            if (word_done) begin
                state_q <= SH_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= SH_BUSY;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/shift_deser.sv
// rtl/shift_deser.sv - serial-in parallel-out receiver with one-deep output holding register
module shift_deser
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             msb_first,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             ovr,
    input  logic             ovr_clr,
    output logic [CNT_W-1:0] bit_cnt
);

    logic             word_done;
    logic [WIDTH-1:0] word;
    out_state_e       out_state_q;
    logic [WIDTH-1:0] dout_q;
    logic             ovr_q;
    logic             consume;

    deser_shift_core #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .msb_first (msb_first),
        .sync_clr  (sync_clr),
        .word_done (word_done),
        .word      (word),
        .bit_cnt   (bit_cnt)
    );

    assign consume = (out_state_q == OUT_FULL) && dout_ready;

    // A held word drained on the same edge frees the slot, so the new word never overruns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_state_q <= OUT_EMPTY;
            dout_q      <= '0;
            ovr_q       <= 1'b0;
        end else begin
            if (word_done && (out_state_q == OUT_FULL) && !consume) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
            if (word_done && ((out_state_q == OUT_EMPTY) || consume)) begin
                dout_q      <= word;
                out_state_q <= OUT_FULL;
            end else if (consume) begin
                out_state_q <= OUT_EMPTY;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = (out_state_q == OUT_FULL);
    assign ovr        = ovr_q;

endmodule

// File: tb/tb_shift_deser.sv
// tb/tb_shift_deser.sv - directed self-checking bench for shift_deser
module tb_shift_deser;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sin = 1'b0;
    logic             sin_valid = 1'b0;
    logic             msb_first = 1'b1;
    logic             sync_clr = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic             ovr;
    logic             ovr_clr = 1'b0;
    logic [CNT_W-1:0] bit_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    logic [WIDTH-1:0] exp_q[$];

    shift_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .msb_first  (msb_first),
        .sync_clr   (sync_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .ovr        (ovr),
        .ovr_clr    (ovr_clr),
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs set; a handshake seen here completes on the next rise.
    task automatic step();
        logic [WIDTH-1:0] e;
        if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_word", {28'd0, dout}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_word", {28'd0, dout}, {28'd0, e});
                n_pop++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic m);
        sin       = b;
        msb_first = m;
        sin_valid = 1'b1;
        step();
        sin_valid = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic m, input logic expect_it);
        logic [WIDTH-1:0] v;
        v = w;
        if (expect_it) exp_q.push_back(w);
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(m ? v[WIDTH-1-i] : v[i], m);
        end
    endtask

    initial begin
        int pops_before;

        // Reset state
        #1;
        chk("rst_dout", {28'd0, dout}, 32'h0);
        chk("rst_valid", {31'd0, dout_valid}, 32'h0);
        chk("rst_ovr", {31'd0, ovr}, 32'h0);
        chk("rst_bit_cnt", {29'd0, bit_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // 1: MSB-first 1,0,1,1 with consumer stalled
        exp_q.push_back(4'b1011);
        send_bit(1'b1, 1'b1); chk("t1_cnt1", {29'd0, bit_cnt}, 32'd1);
        send_bit(1'b0, 1'b1); chk("t1_cnt2", {29'd0, bit_cnt}, 32'd2);
        send_bit(1'b1, 1'b1); chk("t1_cnt3", {29'd0, bit_cnt}, 32'd3);
        chk("t1_valid_early", {31'd0, dout_valid}, 32'h0);
        send_bit(1'b1, 1'b1); chk("t1_cnt0", {29'd0, bit_cnt}, 32'd0);
        chk("t1_dout", {28'd0, dout}, 32'hB);
        chk("t1_valid", {31'd0, dout_valid}, 32'h1);
        dout_ready = 1'b1; step(); dout_ready = 1'b0;
        chk("t1_drained", {31'd0, dout_valid}, 32'h0);

        // 2: LSB-first, direction toggled mid-word must be ignored
        exp_q.push_back(4'b1101);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        chk("t2_dout", {28'd0, dout}, 32'hD);
        dout_ready = 1'b1; step(); dout_ready = 1'b0;

        // 3: overrun, clear, and set-wins-over-clear
        send_word(4'hA, 1'b1, 1'b1);
        send_word(4'h5, 1'b1, 1'b0);
        chk("t3_dout_held", {28'd0, dout}, 32'hA);
        chk("t3_ovr", {31'd0, ovr}, 32'h1);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        chk("t3_ovr_clr", {31'd0, ovr}, 32'h0);
        send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
        ovr_clr = 1'b1; send_bit(1'b0, 1'b1); ovr_clr = 1'b0;
        chk("t3_set_wins", {31'd0, ovr}, 32'h1);
        chk("t3_dout_still", {28'd0, dout}, 32'hA);
        dout_ready = 1'b1; step(); dout_ready = 1'b0;
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        chk("t3_ovr_final", {31'd0, ovr}, 32'h0);

        // 4: streaming with consumer always ready
        dout_ready = 1'b1;
        pops_before = n_pop;
        send_word(4'h3, 1'b1, 1'b1);
        send_word(4'hC, 1'b1, 1'b1);
        send_word(4'h9, 1'b1, 1'b1);
        step(); step();
        chk("t4_words_seen", n_pop - pops_before, 32'd3);
        chk("t4_ovr", {31'd0, ovr}, 32'h0);
        chk("t4_empty", {31'd0, dout_valid}, 32'h0);
        dout_ready = 1'b0;

        // 5: abort after two bits, with a simultaneous bit that must be dropped
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        sync_clr = 1'b1; send_bit(1'b1, 1'b1); sync_clr = 1'b0;
        chk("t5_cnt_clr", {29'd0, bit_cnt}, 32'd0);
        chk("t5_no_word", {31'd0, dout_valid}, 32'h0);
        send_word(4'h6, 1'b1, 1'b1);
        chk("t5_dout", {28'd0, dout}, 32'h6);
        dout_ready = 1'b1; step(); dout_ready = 1'b0;

        // 6: asynchronous reset mid-cycle with state held everywhere
        send_word(4'hF, 1'b1, 1'b0);
        send_word(4'h0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        chk("t6_pre_valid", {31'd0, dout_valid}, 32'h1);
        chk("t6_pre_ovr", {31'd0, ovr}, 32'h1);
        chk("t6_pre_cnt", {29'd0, bit_cnt}, 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("t6_dout", {28'd0, dout}, 32'h0);
        chk("t6_valid", {31'd0, dout_valid}, 32'h0);
        chk("t6_ovr", {31'd0, ovr}, 32'h0);
        chk("t6_cnt", {29'd0, bit_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        send_word(4'h7, 1'b1, 1'b1);
        chk("t6_resume", {28'd0, dout}, 32'h7);
        dout_ready = 1'b1; step(); dout_ready = 1'b0;
        chk("sb_leftover", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
